// File: rtl/key_setpoint_ctrl_if.sv
// Key pulse input and set-point/display outputs of the set-point editor.
// The slave side is the editor; the master side is the key stage / display.
interface key_setpoint_ctrl_if #(
    parameter int VAL_W = 8
);
    logic [2:0]       key_pulse;
    logic [VAL_W-1:0] value;
    logic [VAL_W-1:0] edit_val;
    logic             editing;
    logic             commit;
    logic             abort;
    logic             blink;

    modport master (
        output key_pulse,
        input  value, edit_val, editing, commit, abort, blink
    );

    modport slave (
        input  key_pulse,
        output value, edit_val, editing, commit, abort, blink
    );
endinterface

// File: rtl/key_setpoint_ctrl.sv
// Key-driven set-point editor: committed value plus a working copy that is
// stepped with wrap-around, accelerating on held keys, with edit timeout and
// a blink indication for the display.
//
// state | meaning
// VIEW  | showing committed value, up/down ignored, blink held on
// EDIT  | stepping working copy, blink toggling, idle timeout armed
module key_setpoint_ctrl #(
    parameter int VAL_W         = 8,
    parameter int VAL_MIN       = 0,
    parameter int VAL_MAX       = 99,
    parameter int VAL_INIT      = 0,
    parameter int STEP_FAST     = 10,
    parameter int REPEAT_THRESH = 4,
    parameter int GAP_CYC       = 25_000_000,
    parameter int TIMEOUT_CYC   = 250_000_000,
    parameter int BLINK_CYC     = 12_500_000
) (
    input logic                clk,
    input logic                rst_n,
    key_setpoint_ctrl_if.slave bus
);

    localparam int IDLE_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam int REP_W    = $clog2(REPEAT_THRESH + 1);
    localparam int BLK_W    = $clog2(BLINK_CYC + 1);

    localparam logic [VAL_W:0]    MIN_X    = (VAL_W + 1)'(VAL_MIN);
    localparam logic [VAL_W:0]    MAX_X    = (VAL_W + 1)'(VAL_MAX);
    localparam logic [VAL_W:0]    FAST_X   = (VAL_W + 1)'(STEP_FAST);
    localparam logic [VAL_W:0]    ONE_X    = (VAL_W + 1)'(1);
    localparam logic [VAL_W-1:0]  INIT_V   = VAL_W'(VAL_INIT);
    localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(IDLE_MAX);
    localparam logic [IDLE_W-1:0] GAP_X    = IDLE_W'(GAP_CYC);
    localparam logic [IDLE_W-1:0] TO_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [REP_W-1:0]  REP_SAT  = REP_W'(REPEAT_THRESH);
    localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);
    localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_CYC - 1);

    typedef enum logic {
        VIEW = 1'b0,
        EDIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [VAL_W-1:0]  value_q, value_d;
    logic [VAL_W-1:0]  work_q, work_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              dir_q, dir_d;      // direction of current run, 1 = down
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              blink_q, blink_d;
    logic              commit_q, commit_d;
    logic              abort_q, abort_d;

    logic              key_up, key_dn, key_mode, any_key;
    logic              run_cont;
    logic [VAL_W:0]    work_x, step, sum, up_res, dn_res;

    assign key_up   = bus.key_pulse[0];
    assign key_dn   = bus.key_pulse[1];
    assign key_mode = bus.key_pulse[2];
    assign any_key  = |bus.key_pulse;

    // Next-state, stepping arithmetic, idle/run/blink counters and output pulses.
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        work_d   = work_q;
        rep_d    = rep_q;
        dir_d    = dir_q;
        blk_d    = blk_q;
        blink_d  = blink_q;
        commit_d = 1'b0;
        abort_d  = 1'b0;

        if (any_key)
            idle_d = '0;
        else if (idle_q == IDLE_SAT)
            idle_d = idle_q;
        else
            idle_d = idle_q + 1'b1;

        // A pulse continues the run only if same direction and not after a long gap.
        run_cont = (rep_q != '0) && (dir_q == key_dn) && (idle_q < GAP_X);
        step     = (run_cont && (rep_q >= REP_SAT)) ? FAST_X : ONE_X;
        work_x   = {1'b0, work_q};
        sum      = work_x + step;
        up_res   = (sum > MAX_X) ? (MIN_X + (sum - MAX_X - ONE_X)) : sum;
        dn_res   = (work_x < (MIN_X + step)) ? (MAX_X - (MIN_X + step - work_x - ONE_X))
                                             : (work_x - step);

        case (state_q)
            VIEW: begin
                blink_d = 1'b1;
                blk_d   = '0;
                if (key_mode) begin
                    state_d = EDIT;
                    work_d  = value_q;
                    rep_d   = '0;
                    idle_d  = '0;
                end
            end
            EDIT: begin
                if (key_mode) begin
                    state_d  = VIEW;
                    value_d  = work_q;
                    commit_d = 1'b1;
                    rep_d    = '0;
                    blink_d  = 1'b1;
                    blk_d    = '0;
                end else if (any_key) begin
                    blink_d = 1'b1;
                    blk_d   = '0;
                    if (key_up && key_dn) begin
                        rep_d = '0;
                    end else begin
                        work_d = key_up ? up_res[VAL_W-1:0] : dn_res[VAL_W-1:0];
                        dir_d  = key_dn;
                        if (!run_cont)
                            rep_d = REP_ONE;
                        else if (rep_q != REP_SAT)
                            rep_d = rep_q + 1'b1;
                    end
                end else if (idle_q == TO_LAST) begin
                    state_d = VIEW;
                    abort_d = 1'b1;
                    work_d  = value_q;
                    blink_d = 1'b1;
                    blk_d   = '0;
                end else if (blk_q == BLK_LAST) begin
                    blink_d = ~blink_q;
                    blk_d   = '0;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
        endcase
    end

    // State and output registers; reset drops the working copy without pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= VIEW;
            value_q  <= INIT_V;
            work_q   <= INIT_V;
            idle_q   <= '0;
            rep_q    <= '0;
            dir_q    <= 1'b0;
            blk_q    <= '0;
            blink_q  <= 1'b1;
            commit_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            work_q   <= work_d;
            idle_q   <= idle_d;
            rep_q    <= rep_d;
            dir_q    <= dir_d;
            blk_q    <= blk_d;
            blink_q  <= blink_d;
            commit_q <= commit_d;
            abort_q  <= abort_d;
        end
    end

    assign bus.value    = value_q;
    assign bus.edit_val = work_q;
    assign bus.editing  = (state_q == EDIT);
    assign bus.commit   = commit_q;
    assign bus.abort    = abort_q;
    assign bus.blink    = blink_q;

endmodule

// File: tb/tb_key_setpoint_ctrl.sv
// Bench for key_setpoint_ctrl: directed scenarios followed by random key
// traffic, every cycle compared against a behavioural model of the editor.
module tb_key_setpoint_ctrl;

    localparam int VAL_W         = 8;
    localparam int VAL_MIN       = 0;
    localparam int VAL_MAX       = 9;
    localparam int VAL_INIT      = 5;
    localparam int STEP_FAST     = 5;
    localparam int REPEAT_THRESH = 3;
    localparam int GAP_CYC       = 8;
    localparam int TIMEOUT_CYC   = 20;
    localparam int BLINK_CYC     = 4;
    localparam int RANGE         = VAL_MAX - VAL_MIN + 1;

    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_UP   = 3'b001;
    localparam logic [2:0] K_DN   = 3'b010;
    localparam logic [2:0] K_MODE = 3'b100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_setpoint_ctrl_if #(.VAL_W(VAL_W)) bus ();

    key_setpoint_ctrl #(
        .VAL_W(VAL_W), .VAL_MIN(VAL_MIN), .VAL_MAX(VAL_MAX), .VAL_INIT(VAL_INIT),
        .STEP_FAST(STEP_FAST), .REPEAT_THRESH(REPEAT_THRESH), .GAP_CYC(GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .BLINK_CYC(BLINK_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model state: expected outputs plus run/timing bookkeeping.
    int m_value, m_work, m_blink, m_edit, m_commit, m_abort;
    int last_pulse, run_len, run_dir, force_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_value    = VAL_INIT;
        m_work     = VAL_INIT;
        m_edit     = 0;
        m_commit   = 0;
        m_abort    = 0;
        m_blink    = 1;
        run_len    = 0;
        run_dir    = 0;
        force_cyc  = 0;
        last_pulse = cyc - 1;
    endtask

    // Expected outputs after the edge that samples key pulses p in cycle cyc.
    task automatic model_step(input logic [2:0] p);
        int gap, dir, step, ofs;
        gap      = cyc - last_pulse - 1;
        m_commit = 0;
        m_abort  = 0;
        if (p[2]) begin
            if (m_edit != 0) begin
                m_value  = m_work;
                m_commit = 1;
                m_edit   = 0;
            end else begin
                m_work    = m_value;
                m_edit    = 1;
                force_cyc = cyc + 1;
            end
            run_len = 0;
        end else if (m_edit != 0 && p[0] && p[1]) begin
            run_len   = 0;
            force_cyc = cyc + 1;
        end else if (m_edit != 0 && (p[0] || p[1])) begin
            dir = p[1] ? 1 : 0;
            if (run_len > 0 && dir == run_dir && gap < GAP_CYC)
                run_len++;
            else
                run_len = 1;
            run_dir   = dir;
            step      = (run_len > REPEAT_THRESH) ? STEP_FAST : 1;
            ofs       = m_work - VAL_MIN + ((dir != 0) ? -step : step);
            m_work    = VAL_MIN + (((ofs % RANGE) + RANGE) % RANGE);
            force_cyc = cyc + 1;
        end else if (m_edit != 0 && p == K_NONE && gap + 1 == TIMEOUT_CYC) begin
            m_abort = 1;
            m_edit  = 0;
            m_work  = m_value;
        end
        if (p != K_NONE)
            last_pulse = cyc;
        if (m_edit != 0)
            m_blink = ((((cyc + 1 - force_cyc) / BLINK_CYC) % 2) == 0) ? 1 : 0;
        else
            m_blink = 1;
    endtask

    task automatic check_all();
        chk("value",    bus.value,    m_value);
        chk("edit_val", bus.edit_val, m_work);
        chk("editing",  bus.editing,  m_edit);
        chk("commit",   bus.commit,   m_commit);
        chk("abort",    bus.abort,    m_abort);
        chk("blink",    bus.blink,    m_blink);
    endtask

    // Drive one cycle of key pulses from a falling edge, check at the next one.
    task automatic tick(input logic [2:0] p);
        bus.key_pulse = p;
        model_step(p);
        cyc++;
        @(negedge clk);
        check_all();
        bus.key_pulse = K_NONE;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(K_NONE);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_phase(input int n, input int dense);
        int r;
        logic [2:0] p;
        for (int i = 0; i < n; i++) begin
            r = (dense != 0) ? $urandom_range(0, 39) : $urandom_range(0, 99);
            if (r < 6)       p = K_UP;
            else if (r < 10) p = K_DN;
            else if (r < 13) p = K_MODE;
            else if (r < 14) p = K_UP | K_DN;
            else if (r < 15) p = 3'($urandom_range(1, 7));
            else             p = K_NONE;
            tick(p);
        end
    endtask

    initial begin
        int exp_acc[5];
        bus.key_pulse = K_NONE;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values while reset is held
        chk("rst_value",    bus.value,    VAL_INIT);
        chk("rst_edit_val", bus.edit_val, VAL_INIT);
        chk("rst_editing",  bus.editing,  0);
        chk("rst_blink",    bus.blink,    1);
        chk("rst_commit",   bus.commit,   0);
        chk("rst_abort",    bus.abort,    0);
        rst_n = 1'b1;
        model_reset();
        tick(K_NONE);

        // Mode with up in VIEW: enter EDIT, up ignored
        tick(K_MODE | K_UP);
        chk("s1_editing",  bus.editing,  1);
        chk("s1_edit_val", bus.edit_val, 5);

        // Commit path
        tick(K_UP);
        chk("s2_up1", bus.edit_val, 6);
        idle(2);
        tick(K_UP);
        chk("s2_up2", bus.edit_val, 7);
        idle(2);
        tick(K_MODE);
        chk("s2_commit", bus.commit, 1);
        chk("s2_value",  bus.value,  7);
        chk("s2_edit",   bus.editing, 0);
        tick(K_NONE);
        chk("s2_commit_end", bus.commit, 0);

        // Acceleration and wrap
        do_reset();
        tick(K_MODE);
        exp_acc = '{6, 7, 8, 3, 8};
        for (int i = 0; i < 5; i++) begin
            tick(K_UP);
            chk("s3_accel", bus.edit_val, exp_acc[i]);
            tick(K_NONE);
        end
        idle(8);
        tick(K_UP);
        chk("s3_slow1", bus.edit_val, 9);
        idle(9);
        tick(K_UP);
        chk("s3_slow2", bus.edit_val, 0);
        idle(3);
        tick(K_DN);
        chk("s3_down_wrap", bus.edit_val, 9);

        // Timeout abort, then pulse on the expiry cycle
        do_reset();
        tick(K_MODE);
        tick(K_UP);
        chk("s4_up", bus.edit_val, 6);
        idle(19);
        chk("s4_no_abort_yet", bus.abort, 0);
        tick(K_NONE);
        chk("s4_abort",    bus.abort,    1);
        chk("s4_editing",  bus.editing,  0);
        chk("s4_value",    bus.value,    5);
        chk("s4_edit_val", bus.edit_val, 5);
        tick(K_MODE);
        tick(K_UP);
        idle(19);
        tick(K_UP);
        chk("s4_pulse_wins", bus.abort,   0);
        chk("s4_still_edit", bus.editing, 1);
        idle(25);

        // Simultaneous keys and blink
        do_reset();
        tick(K_MODE);
        tick(K_UP);
        tick(K_UP | K_DN);
        chk("s5_both", bus.edit_val, 6);
        tick(K_UP);
        chk("s5_after_both", bus.edit_val, 7);
        idle(4);
        chk("s5_blink_off", bus.blink, 0);
        idle(4);
        chk("s5_blink_on", bus.blink, 1);
        idle(5);
        tick(K_DN);
        chk("s5_blink_forced", bus.blink, 1);

        // Reset mid-edit
        do_reset();
        tick(K_MODE);
        tick(K_UP);
        idle(2);
        tick(K_UP);
        idle(2);
        tick(K_UP);
        chk("s6_work", bus.edit_val, 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_value",   bus.value,    5);
        chk("s6_edit",    bus.editing,  0);
        chk("s6_editval", bus.edit_val, 5);
        chk("s6_commit",  bus.commit,   0);
        chk("s6_abort",   bus.abort,    0);
        chk("s6_blink",   bus.blink,    1);
        @(negedge clk);
        chk("s6_commit_hold", bus.commit, 0);
        rst_n = 1'b1;
        model_reset();
        tick(K_NONE);

        // Random traffic against the model
        rand_phase(800, 0);
        rand_phase(800, 1);
        rand_phase(400, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
